exec_seq: RTL and testbench

Multi-cycle execute sequencer for the integer ALU and branch comparator, decoded by funct3. Accepts one operation per valid/ready handshake and returns one result per handshake. Logic ops, add/sub, set-less-than and branch compares complete in one cycle; shifts iterate `SHIFT_STEP` bit positions per cycle, trading latency for shifter area. Sits between decode and writeback/PC-select in the core.

---
 rtl/exec_seq_pkg.sv | 39 +++
 rtl/exec_seq_if.sv | 27 ++
 rtl/exec_seq_shift_unit.sv | 63 ++++++
 rtl/exec_seq.sv | 129 ++++++++++++
 tb/tb_exec_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_seq_pkg.sv
// funct3 encodings for the integer and branch opcodes, plus the shared
// definitions of the execute sequencer.
package f3OpInt;
    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SLL  = 3'b001;
    localparam logic [2:0] SLT  = 3'b010;
    localparam logic [2:0] SLTU = 3'b011;
    localparam logic [2:0] XOR  = 3'b100;
    localparam logic [2:0] SR   = 3'b101;
    localparam logic [2:0] OR   = 3'b110;
    localparam logic [2:0] AND  = 3'b111;
endpackage

package f3Br;
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;
endpackage

package execPkg;
    import f3OpInt::*;
    import f3Br::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SHAMT_W = 5;

    function automatic bit step_legal(input int step);
        return (step == 1) || (step == 2) || (step == 4) ||
               (step == 8) || (step == 16) || (step == 32);
    endfunction
endpackage

// File: rtl/exec_seq_if.sv
// Operation/result handshake bundle between decode and the execute sequencer.
interface exec_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            in_branch;
    logic [2:0]      in_funct3;
    logic            in_alt;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_taken;
    logic            out_illegal;

    modport master (
        output in_valid, in_branch, in_funct3, in_alt, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_branch, in_funct3, in_alt, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_taken, out_illegal
    );
endinterface

// File: rtl/exec_seq_shift_unit.sv
// Iterative shifter: moves the working register by up to SHIFT_STEP bits per
// enabled cycle; done flags the step that brings the counter to zero.
module exec_shift_unit
    import execPkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [XLEN-1:0]    load_val,
    input  logic [SHAMT_W-1:0] load_cnt,
    input  logic               dir_left,
    input  logic               arith,
    input  logic               en,
    output logic [XLEN-1:0]    result,
    output logic               done
);
    localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W + 1)'(SHIFT_STEP);

    logic [XLEN-1:0]        work;
    logic signed [XLEN-1:0] work_s;
    logic [XLEN-1:0]        work_next;
    logic [SHAMT_W-1:0]     cnt;
    logic [SHAMT_W-1:0]     step;
    logic                   left_q;
    logic                   arith_q;

    // Last step is clipped to the remaining count so the total is exact.
    always_comb begin
        step = ({1'b0, cnt} < STEP_V) ? cnt : STEP_V[SHAMT_W-1:0];
        work_s = work;
        if (left_q)
            work_next = work << step;
        else if (arith_q)
            work_next = $unsigned(work_s >>> step);
        else
            work_next = work >> step;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_cnt;
        else if (en)
            cnt <= cnt - step;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            work    <= load_val;
            left_q  <= dir_left;
            arith_q <= arith;
        end else if (en) begin
            work <= work_next;
        end
    end

    assign result = work;
    assign done   = (cnt == step);
endmodule

// File: rtl/exec_seq.sv
// Execute sequencer: single-cycle ALU/branch compare with an iterative shifter.
// Outputs read as zero whenever no result is being presented.
module exec_seq
    import execPkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic     clk,
    input  logic     rst,
    exec_seq_if.slave bus
);
    if (!step_legal(SHIFT_STEP)) begin : g_bad_step
        $error("exec_seq: SHIFT_STEP must be 1, 2, 4, 8, 16 or 32");
    end

    state_t state, state_next;

    logic                   accept;
    logic                   is_shift;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0]        int_res;
    logic                   br_taken;
    logic                   br_illegal;
    logic [XLEN-1:0]        res_q;
    logic                   taken_q;
    logic                   illegal_q;
    logic                   shift_q;
    logic [XLEN-1:0]        sh_res;
    logic                   sh_done;

    assign accept   = bus.in_valid && (state == IDLE);
    assign is_shift = !bus.in_branch &&
                      ((bus.in_funct3 == f3OpInt::SLL) || (bus.in_funct3 == f3OpInt::SR));

    always_comb begin
        a_s     = bus.in_a;
        b_s     = bus.in_b;
        int_res = '0;
        case (bus.in_funct3)
            f3OpInt::ADD:  int_res = bus.in_alt ? bus.in_a - bus.in_b : bus.in_a + bus.in_b;
            f3OpInt::SLT:  int_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            f3OpInt::SLTU: int_res = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
            f3OpInt::XOR:  int_res = bus.in_a ^ bus.in_b;
            f3OpInt::OR:   int_res = bus.in_a | bus.in_b;
            f3OpInt::AND:  int_res = bus.in_a & bus.in_b;
            default:       int_res = '0;
        endcase
    end

    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (bus.in_funct3)
            f3Br::BEQ:  br_taken = (bus.in_a == bus.in_b);
            f3Br::BNE:  br_taken = (bus.in_a != bus.in_b);
            f3Br::BLT:  br_taken = (a_s < b_s);
            f3Br::BGE:  br_taken = (a_s >= b_s);
            f3Br::BLTU: br_taken = (bus.in_a < bus.in_b);
            f3Br::BGEU: br_taken = (bus.in_a >= bus.in_b);
            default:    br_illegal = 1'b1;
        endcase
    end

    exec_shift_unit #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_shift),
        .load_val (bus.in_a),
        .load_cnt (bus.in_b[SHAMT_W-1:0]),
        .dir_left (bus.in_funct3 == f3OpInt::SLL),
        .arith    (bus.in_alt),
        .en       (state == SHIFT),
        .result   (sh_res),
        .done     (sh_done)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (bus.in_valid)
                    state_next = (is_shift && (bus.in_b[SHAMT_W-1:0] != '0)) ? SHIFT : DONE;
            SHIFT:
                if (sh_done)
                    state_next = DONE;
            DONE:
                if (bus.out_ready)
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    // Operands are consumed only on the accept edge; nothing here is reset
    // because the outputs are gated by the DONE state.
    always_ff @(posedge clk) begin
        if (accept) begin
            res_q     <= bus.in_branch ? '0 : int_res;
            taken_q   <= bus.in_branch && br_taken;
            illegal_q <= bus.in_branch && br_illegal;
            shift_q   <= is_shift;
        end
    end

    always_comb begin
        bus.in_ready    = (state == IDLE);
        bus.out_valid   = (state == DONE);
        bus.out_result  = '0;
        bus.out_taken   = 1'b0;
        bus.out_illegal = 1'b0;
        if (state == DONE) begin
            bus.out_result  = shift_q ? sh_res : res_q;
            bus.out_taken   = taken_q;
            bus.out_illegal = illegal_q;
        end
    end
endmodule

// File: tb/tb_exec_seq.sv
// Directed bench driving two sequencers (SHIFT_STEP 1 and 4) with identical
// operations, checked against a latency/result model and literal expectations.
module tb_exec_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_branch;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    exec_seq_if #(.XLEN(32)) bus1 ();
    exec_seq_if #(.XLEN(32)) bus4 ();

    exec_seq #(.XLEN(32), .SHIFT_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    exec_seq #(.XLEN(32), .SHIFT_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus1.in_valid  = in_valid;   assign bus4.in_valid  = in_valid;
    assign bus1.in_branch = in_branch;  assign bus4.in_branch = in_branch;
    assign bus1.in_funct3 = in_funct3;  assign bus4.in_funct3 = in_funct3;
    assign bus1.in_alt    = in_alt;     assign bus4.in_alt    = in_alt;
    assign bus1.in_a      = in_a;       assign bus4.in_a      = in_a;
    assign bus1.in_b      = in_b;       assign bus4.in_b      = in_b;
    assign bus1.out_ready = out_ready;  assign bus4.out_ready = out_ready;

    logic        ov[2];
    logic        ir[2];
    logic        tk[2];
    logic        il[2];
    logic [31:0] res[2];
    assign ov[0] = bus1.out_valid;   assign ov[1] = bus4.out_valid;
    assign ir[0] = bus1.in_ready;    assign ir[1] = bus4.in_ready;
    assign tk[0] = bus1.out_taken;   assign tk[1] = bus4.out_taken;
    assign il[0] = bus1.out_illegal; assign il[1] = bus4.out_illegal;
    assign res[0] = bus1.out_result; assign res[1] = bus4.out_result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] r;
        logic        t;
        logic        il;
        int          lat;
    } exp_t;

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic exp_t model(input logic br, input logic [2:0] f3, input logic alt,
                                   input logic [31:0] a, input logic [31:0] b, input int step);
        exp_t e;
        int   sh;
        e  = '0;
        e.lat = 1;
        sh = int'(b[4:0]);
        if (br) begin
            case (f3)
                3'd0: e.t = (a == b);
                3'd1: e.t = (a != b);
                3'd4: e.t = ($signed(a) < $signed(b));
                3'd5: e.t = ($signed(a) >= $signed(b));
                3'd6: e.t = (a < b);
                3'd7: e.t = (a >= b);
                default: e.il = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0: e.r = alt ? a - b : a + b;
                3'd1: begin e.r = a << sh; e.lat = 1 + (sh + step - 1) / step; end
                3'd2: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: e.r = (a < b) ? 32'd1 : 32'd0;
                3'd4: e.r = a ^ b;
                3'd5: begin
                    e.r = alt ? $unsigned($signed(a) >>> sh) : a >> sh;
                    e.lat = 1 + (sh + step - 1) / step;
                end
                3'd6: e.r = a | b;
                default: e.r = a & b;
            endcase
        end
        return e;
    endfunction

    bit          started = 1'b0;
    bit          busy[2] = '{1'b0, 1'b0};
    int          rem[2]  = '{0, 0};
    exp_t        expv[2];

    always @(posedge clk) begin
        started <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] <= 1'b0;
                rem[k]  <= 0;
            end else if (!busy[k]) begin
                if (in_valid) begin
                    busy[k] <= 1'b1;
                    expv[k] <= model(in_branch, in_funct3, in_alt, in_a, in_b, step_of(k));
                    rem[k]  <= model(in_branch, in_funct3, in_alt, in_a, in_b, step_of(k)).lat - 1;
                end
            end else if (rem[k] > 0) begin
                rem[k] <= rem[k] - 1;
            end else if (out_ready) begin
                busy[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(!busy[k]));
                chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(busy[k] && rem[k] == 0));
                if (busy[k] && rem[k] == 0) begin
                    chk($sformatf("out_result[%0d]", k), res[k], expv[k].r);
                    chk($sformatf("out_taken[%0d]", k), 32'(tk[k]), 32'(expv[k].t));
                    chk($sformatf("out_illegal[%0d]", k), 32'(il[k]), 32'(expv[k].il));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] got_res[2];
    logic        got_tk[2];
    logic        got_il[2];
    int          got_lat[2];

    task automatic start(input logic br, input logic [2:0] f3, input logic alt,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        in_branch = br;
        in_funct3 = f3;
        in_alt    = alt;
        in_a      = a;
        in_b      = b;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_branch = 1'($urandom);
        in_funct3 = 3'($urandom);
        in_alt    = 1'($urandom);
        in_a      = $urandom;
        in_b      = $urandom;
    endtask

    task automatic finish_op(input int hold);
        bit seen[2];
        int cyc;
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        got_lat[0] = -1;
        got_lat[1] = -1;
        cyc = 1;
        while (!(seen[0] && seen[1]) && cyc <= 100) begin
            for (int k = 0; k < 2; k++) begin
                if (!seen[k] && ov[k] === 1'b1) begin
                    seen[k]    = 1'b1;
                    got_lat[k] = cyc;
                    got_res[k] = res[k];
                    got_tk[k]  = tk[k];
                    got_il[k]  = il[k];
                end
            end
            if (!(seen[0] && seen[1])) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        for (int k = 0; k < 2; k++)
            if (!seen[k]) chk($sformatf("timeout_valid[%0d]", k), 32'(ov[k]), 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("hold_valid[%0d]", k), 32'(ov[k]), 32'd1);
                chk($sformatf("hold_result[%0d]", k), res[k], got_res[k]);
                chk($sformatf("hold_taken[%0d]", k), 32'(tk[k]), 32'(got_tk[k]));
                chk($sformatf("hold_illegal[%0d]", k), 32'(il[k]), 32'(got_il[k]));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input logic br, input logic [2:0] f3, input logic alt,
                       input logic [31:0] a, input logic [31:0] b, input int hold);
        start(br, f3, alt, a, b);
        finish_op(hold);
    endtask

    task automatic lit(input string nm, input int k, input logic [31:0] r, input logic t,
                       input logic ill, input int lat);
        chk({nm, "_result"}, got_res[k], r);
        chk({nm, "_taken"}, 32'(got_tk[k]), 32'(t));
        chk({nm, "_illegal"}, 32'(got_il[k]), 32'(ill));
        chk({nm, "_latency"}, 32'(got_lat[k]), 32'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_branch = 1'b0; in_funct3 = 3'd0;
        in_alt = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_in_ready", 32'(ir[k]), 32'd1);
            chk("reset_out_valid", 32'(ov[k]), 32'd0);
            chk("reset_result", res[k], 32'd0);
            chk("reset_taken", 32'(tk[k]), 32'd0);
            chk("reset_illegal", 32'(il[k]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1, 0);
        lit("add_wrap", 0, 32'h0, 1'b0, 1'b0, 1);
        run(1'b0, 3'b000, 1'b1, 32'h0, 32'h1, 0);
        lit("sub", 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        run(1'b0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 0);
        lit("slt", 0, 32'h1, 1'b0, 1'b0, 1);
        run(1'b0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 0);
        lit("sltu", 0, 32'h0, 1'b0, 1'b0, 1);
        run(1'b1, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'h0, 0);
        lit("blt", 0, 32'h0, 1'b1, 1'b0, 1);
        run(1'b1, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'h0, 0);
        lit("bgeu", 0, 32'h0, 1'b1, 1'b0, 1);
        run(1'b1, 3'b000, 1'b0, 32'h5, 32'h5, 0);
        lit("beq", 1, 32'h0, 1'b1, 1'b0, 1);
        run(1'b0, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        lit("xor", 0, 32'h0FF0_0FF0, 1'b0, 1'b0, 1);

        run(1'b0, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_003F, 0);
        lit("sra31_s1", 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
        lit("sra31_s4", 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 9);
        run(1'b0, 3'b101, 1'b0, 32'hF000_0000, 32'h4, 0);
        lit("srl4_s1", 0, 32'h0F00_0000, 1'b0, 1'b0, 5);
        lit("srl4_s4", 1, 32'h0F00_0000, 1'b0, 1'b0, 2);
        run(1'b0, 3'b001, 1'b0, 32'h1234_5678, 32'h20, 0);
        lit("sl0", 0, 32'h1234_5678, 1'b0, 1'b0, 1);
        run(1'b0, 3'b001, 1'b0, 32'h1, 32'h5, 0);
        lit("sl5_s4", 1, 32'h20, 1'b0, 1'b0, 3);
        lit("sl5_s1", 0, 32'h20, 1'b0, 1'b0, 6);

        run(1'b1, 3'b010, 1'b0, 32'h1, 32'h1, 5);
        lit("br_illegal", 0, 32'h0, 1'b0, 1'b1, 1);
        chk("ready_after_handshake", 32'(ir[0]), 32'd1);

        start(1'b0, 3'b101, 1'b1, 32'h8000_0000, 32'h1F);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("abort_in_ready", 32'(ir[k]), 32'd1);
            chk("abort_out_valid", 32'(ov[k]), 32'd0);
            chk("abort_result", res[k], 32'd0);
            chk("abort_taken", 32'(tk[k]), 32'd0);
            chk("abort_illegal", 32'(il[k]), 32'd0);
        end
        repeat (40) @(posedge clk);
        #1;
        run(1'b0, 3'b000, 1'b0, 32'h2, 32'h3, 0);
        lit("add_after_abort", 0, 32'h5, 1'b0, 1'b0, 1);
        lit("add_after_abort4", 1, 32'h5, 1'b0, 1'b0, 1);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
